// File: rtl/chan_frame_deserializer_if.sv
// Byte stream leaving the frame deserializer: one registered slot, valid/ready handshake,
// tagged with the index of the serial channel the byte arrived on.
interface chan_frame_deserializer_if #(
  parameter int DATA_BITS = 8,
  parameter int CH_W      = 3
);
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic [CH_W-1:0]      out_chan;

  modport master (
    output out_valid,
    output out_data,
    output out_chan,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_chan,
    output out_ready
  );
endinterface

// File: rtl/chan_frame_deserializer.sv
// Frames NUM_CH independent start/data/stop serial lines into bytes and merges them
// round-robin onto one tagged valid/ready stream, with framing-error and overrun status.
module chan_frame_deserializer #(
  parameter int NUM_CH    = 7,
  parameter int DATA_BITS = 8,
  parameter int CH_W      = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     serial_in,
  chan_frame_deserializer_if.master out_if,
  input  logic                  clear_flags,
  output logic [ERR_CNT_W-1:0]  frame_err_cnt,
  output logic [NUM_CH-1:0]     overrun
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int SUM_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]        NUM_CH_W = (CH_W + 1)'(NUM_CH);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_BREAK = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ch_state_t;

  ch_state_t            state_r   [NUM_CH];
  logic [CNT_W-1:0]     bit_cnt_r [NUM_CH];
  logic [DATA_BITS-1:0] shift_r   [NUM_CH];
  logic [DATA_BITS-1:0] hold_r    [NUM_CH];
  logic [NUM_CH-1:0]    pending_r;
  logic [NUM_CH-1:0]    overrun_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;
  logic                 out_valid_r;
  logic [DATA_BITS-1:0] out_data_r;
  logic [CH_W-1:0]      out_chan_r;
  logic [CH_W-1:0]      rr_ptr_r;

  logic [NUM_CH-1:0]    done_s;
  logic [NUM_CH-1:0]    ferr_s;
  logic                 load_s;
  logic                 grant_found_s;
  logic [CH_W-1:0]      grant_s;
  logic [CH_W:0]        scan_sum_s;
  logic [CH_W:0]        scan_idx_s;
  logic                 scan_hit_s;
  logic [NUM_CH-1:0]    drain_s;
  logic [NUM_CH-1:0]    store_s;
  logic [NUM_CH-1:0]    ovr_evt_s;
  logic [SUM_W-1:0]     err_sum_s;
  logic [ERR_CNT_W:0]   err_next_s;

  // Per-channel framer; BREAK holds off start detection until the line has been seen idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_r[c]   <= ST_BREAK;
        bit_cnt_r[c] <= '0;
        shift_r[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        case (state_r[c])
          ST_BREAK: begin
            if (serial_in[c]) begin
              state_r[c] <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            if (!serial_in[c]) begin
              state_r[c]   <= ST_DATA;
              bit_cnt_r[c] <= '0;
            end
          end
          ST_DATA: begin
            shift_r[c][bit_cnt_r[c]] <= serial_in[c];
            if (bit_cnt_r[c] == LAST_BIT) begin
              state_r[c] <= ST_STOP;
            end else begin
              bit_cnt_r[c] <= bit_cnt_r[c] + CNT_W'(1);
            end
          end
          ST_STOP: begin
            state_r[c] <= serial_in[c] ? ST_IDLE : ST_BREAK;
          end
          default: begin
            state_r[c] <= ST_BREAK;
          end
        endcase
      end
    end
  end

  // Stop-bit decode: a high stop bit completes the byte, a low one is a framing error.
  always_comb begin
    done_s = '0;
    ferr_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (state_r[c] == ST_STOP) begin
        done_s[c] = serial_in[c];
        ferr_s[c] = !serial_in[c];
      end else begin
        done_s[c] = 1'b0;
        ferr_s[c] = 1'b0;
      end
    end
  end

  // Round-robin search for the first pending channel at or after rr_ptr, wrapping at NUM_CH.
  always_comb begin
    load_s        = !out_valid_r || out_if.out_ready;
    grant_found_s = 1'b0;
    grant_s       = '0;
    scan_sum_s    = '0;
    scan_idx_s    = '0;
    scan_hit_s    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_sum_s    = {1'b0, rr_ptr_r} + (CH_W + 1)'(i);
      scan_idx_s    = (scan_sum_s >= NUM_CH_W) ? (scan_sum_s - NUM_CH_W) : scan_sum_s;
      scan_hit_s    = !grant_found_s && pending_r[scan_idx_s[CH_W-1:0]];
      grant_s       = scan_hit_s ? scan_idx_s[CH_W-1:0] : grant_s;
      grant_found_s = grant_found_s | scan_hit_s;
    end
  end

  // A draining channel frees its holding register in time to accept a byte completing on the same edge.
  always_comb begin
    if (load_s && grant_found_s) begin
      drain_s = {{(NUM_CH - 1){1'b0}}, 1'b1} << grant_s;
    end else begin
      drain_s = '0;
    end
    store_s   = done_s & (~pending_r | drain_s);
    ovr_evt_s = done_s & pending_r & ~drain_s;
  end

  // Count of framing errors this cycle and the saturated running total.
  always_comb begin
    err_sum_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      err_sum_s = err_sum_s + SUM_W'(ferr_s[c]);
    end
    err_next_s = {1'b0, err_cnt_r} + (ERR_CNT_W + 1)'(err_sum_s);
  end

  // Holding registers and the single output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_chan_r  <= '0;
      rr_ptr_r    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        hold_r[c] <= '0;
      end
    end else begin
      pending_r <= (pending_r & ~drain_s) | store_s;
      for (int c = 0; c < NUM_CH; c++) begin
        if (store_s[c]) begin
          hold_r[c] <= shift_r[c];
        end
      end
      if (load_s) begin
        if (grant_found_s) begin
          out_valid_r <= 1'b1;
          out_data_r  <= hold_r[grant_s];
          out_chan_r  <= grant_s;
          rr_ptr_r    <= (grant_s == LAST_CH) ? '0 : (grant_s + CH_W'(1));
        end else begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  // Status: clear_flags wins over any event arriving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_r <= '0;
      overrun_r <= '0;
    end else if (clear_flags) begin
      err_cnt_r <= '0;
      overrun_r <= '0;
    end else begin
      err_cnt_r <= err_next_s[ERR_CNT_W] ? ERR_MAX : err_next_s[ERR_CNT_W-1:0];
      overrun_r <= overrun_r | ovr_evt_s;
    end
  end

  assign out_if.out_valid = out_valid_r;
  assign out_if.out_data  = out_data_r;
  assign out_if.out_chan  = out_chan_r;
  assign frame_err_cnt    = err_cnt_r;
  assign overrun          = overrun_r;

endmodule

// File: tb/tb_chan_frame_deserializer.sv
// Directed and randomized bench for chan_frame_deserializer; expectations come from a
// frame-schedule model that knows which cycle each stop bit is sampled on.
module tb_chan_frame_deserializer;

  localparam int NCH = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] ser = 7'h7F;
  logic       clr = 1'b0;
  logic [7:0] err_cnt;
  logic [6:0] ovr;
  bit         ready_v = 1'b1;

  chan_frame_deserializer_if #(.DATA_BITS(8), .CH_W(3)) bus ();

  chan_frame_deserializer #(.NUM_CH(7), .DATA_BITS(8), .CH_W(3), .ERR_CNT_W(8)) dut (
    .clk           (clk),
    .reset         (rst),
    .serial_in     (ser),
    .out_if        (bus),
    .clear_flags   (clr),
    .frame_err_cnt (err_cnt),
    .overrun       (ovr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-channel line schedule: entry = {byte[15:8], tag[2:1], bit[0]}; tag 1 = good stop, 2 = bad stop.
  int unsigned txq [NCH][$];
  logic [1:0]  ev_tag  [NCH];
  logic [7:0]  ev_byte [NCH];
  logic [10:0] beat_log [$];

  // Reference state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_rr;
  logic [7:0] m_hold [NCH];
  bit   [6:0] m_pend;
  bit   [6:0] m_ovr;
  int         m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_bit(input int c, input bit v, input int tag, input logic [7:0] b);
    txq[c].push_back((32'(b) << 8) | (32'(tag) << 1) | 32'(v));
  endtask

  task automatic push_idle(input int c, input int n, input bit v);
    for (int i = 0; i < n; i++) push_bit(c, v, 0, 8'h00);
  endtask

  task automatic push_frame(input int c, input logic [7:0] b, input bit good);
    push_bit(c, 1'b0, 0, 8'h00);
    for (int i = 0; i < 8; i++) push_bit(c, b[i], 0, 8'h00);
    push_bit(c, good, good ? 1 : 2, b);
  endtask

  task automatic model_step();
    bit       load;
    bit       found;
    int       g;
    int       idx;
    int       nerr;
    bit [6:0] oldp;
    bit [6:0] ovr_ev;
    if (rst) begin
      m_valid = 0; m_data = 8'h00; m_chan = 0; m_rr = 0;
      m_pend = '0; m_ovr = '0; m_err = 0;
      for (int c = 0; c < NCH; c++) m_hold[c] = 8'h00;
    end else begin
      load = !m_valid || ready_v;
      found = 0; g = 0; oldp = m_pend; ovr_ev = '0; nerr = 0;
      if (load) begin
        for (int i = 0; i < NCH; i++) begin
          idx = (m_rr + i) % NCH;
          if (!found && oldp[idx]) begin found = 1; g = idx; end
        end
        if (found) begin
          m_valid = 1; m_data = m_hold[g]; m_chan = g;
          m_pend[g] = 0; m_rr = (g + 1) % NCH;
        end else begin
          m_valid = 0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (ev_tag[c] == 2'd1) begin
          if (!oldp[c] || (load && found && g == c)) begin
            m_hold[c] = ev_byte[c]; m_pend[c] = 1;
          end else begin
            ovr_ev[c] = 1;
          end
        end else if (ev_tag[c] == 2'd2) begin
          nerr++;
        end
      end
      if (clr) begin
        m_err = 0; m_ovr = '0;
      end else begin
        m_err = (m_err + nerr > 255) ? 255 : m_err + nerr;
        m_ovr = m_ovr | ovr_ev;
      end
    end
  endtask

  task automatic tick();
    int unsigned e;
    for (int c = 0; c < NCH; c++) begin
      if (txq[c].size() > 0) begin
        e = txq[c].pop_front();
        ser[c] = e[0]; ev_tag[c] = e[2:1]; ev_byte[c] = e[15:8];
      end else begin
        ser[c] = 1'b1; ev_tag[c] = 2'd0; ev_byte[c] = 8'h00;
      end
    end
    bus.out_ready = ready_v;
    if (bus.out_valid && ready_v && !rst) beat_log.push_back({bus.out_chan, bus.out_data});
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", 32'(bus.out_data), 32'(m_data));
      chk("out_chan", 32'(bus.out_chan), 32'(m_chan));
    end
    chk("frame_err_cnt", 32'(err_cnt), 32'(m_err));
    chk("overrun", 32'(ovr), 32'(m_ovr));
  endtask

  function automatic bit queues_busy();
    bit busy = 0;
    for (int c = 0; c < NCH; c++) if (txq[c].size() > 0) busy = 1;
    return busy;
  endfunction

  task automatic run_out(input int extra);
    int n = 0;
    while (queues_busy() && n < 4000) begin tick(); n++; end
    chk("drain bound", 32'(queues_busy()), 32'd0);
    repeat (extra) tick();
  endtask

  function automatic logic [10:0] log_at(input int i);
    if (i < beat_log.size()) return beat_log[i];
    return 11'h7FF;
  endfunction

  initial begin
    bus.out_ready = 1'b1;
    for (int c = 0; c < NCH; c++) begin ev_tag[c] = 2'd0; ev_byte[c] = 8'h00; end
    // Reset and its visible state
    rst = 1'b1;
    repeat (3) tick();
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data", 32'(bus.out_data), 32'd0);
    chk("reset out_chan", 32'(bus.out_chan), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    chk("reset overrun", 32'(ovr), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // 1: single 0xA5 frame on ch0
    beat_log.delete();
    push_frame(0, 8'hA5, 1'b1);
    run_out(4);
    chk("t1 beats", 32'(beat_log.size()), 32'd1);
    chk("t1 beat0", 32'(log_at(0)), 32'({3'd0, 8'hA5}));

    // 2: three channels finish together, then ch0/ch6 race after the pointer wraps
    beat_log.delete();
    push_frame(2, 8'h12, 1'b1); push_frame(5, 8'h55, 1'b1); push_frame(6, 8'h66, 1'b1);
    run_out(5);
    push_frame(0, 8'h01, 1'b1); push_frame(6, 8'h06, 1'b1);
    run_out(5);
    chk("t2 beats", 32'(beat_log.size()), 32'd5);
    chk("t2 beat0", 32'(log_at(0)), 32'({3'd2, 8'h12}));
    chk("t2 beat1", 32'(log_at(1)), 32'({3'd5, 8'h55}));
    chk("t2 beat2", 32'(log_at(2)), 32'({3'd6, 8'h66}));
    chk("t2 wrap beat3", 32'(log_at(3)), 32'({3'd0, 8'h01}));
    chk("t2 wrap beat4", 32'(log_at(4)), 32'({3'd6, 8'h06}));

    // 3: back-to-back frames on ch1 with the consumer stalled
    beat_log.delete();
    ready_v = 1'b0;
    push_frame(1, 8'h11, 1'b1); push_frame(1, 8'h22, 1'b1); push_frame(1, 8'h33, 1'b1);
    run_out(3);
    chk("t3 overrun", 32'(ovr), 32'h02);
    ready_v = 1'b1;
    repeat (5) tick();
    chk("t3 beats", 32'(beat_log.size()), 32'd2);
    chk("t3 beat0", 32'(log_at(0)), 32'({3'd1, 8'h11}));
    chk("t3 beat1", 32'(log_at(1)), 32'({3'd1, 8'h22}));

    // 4: bad stop bit, long break, then a clean frame on ch3
    beat_log.delete();
    push_frame(3, 8'hC3, 1'b0);
    push_idle(3, 20, 1'b0);
    push_idle(3, 1, 1'b1);
    push_frame(3, 8'h5A, 1'b1);
    run_out(4);
    chk("t4 err_cnt", 32'(err_cnt), 32'd1);
    chk("t4 beats", 32'(beat_log.size()), 32'd1);
    chk("t4 beat0", 32'(log_at(0)), 32'({3'd3, 8'h5A}));

    // 5: reset lands mid-frame on ch4 and releases with the line low
    beat_log.delete();
    push_bit(4, 1'b0, 0, 8'h00); push_bit(4, 1'b1, 0, 8'h00);
    push_bit(4, 1'b0, 0, 8'h00); push_bit(4, 1'b1, 0, 8'h00);
    run_out(0);
    rst = 1'b1;
    push_idle(4, 2, 1'b0);
    run_out(0);
    rst = 1'b0;
    push_idle(4, 12, 1'b0);
    run_out(0);
    chk("t5 quiet", 32'(beat_log.size()), 32'd0);
    chk("t5 quiet err", 32'(err_cnt), 32'd0);
    push_idle(4, 2, 1'b1);
    push_frame(4, 8'h5A, 1'b1);
    run_out(4);
    chk("t5 beats", 32'(beat_log.size()), 32'd1);
    chk("t5 beat0", 32'(log_at(0)), 32'({3'd4, 8'h5A}));

    // 6: counter saturation and clear_flags
    ready_v = 1'b0;
    push_frame(1, 8'h11, 1'b1); push_frame(1, 8'h22, 1'b1); push_frame(1, 8'h33, 1'b1);
    run_out(1);
    for (int r = 0; r < 37; r++) begin
      for (int c = 0; c < NCH; c++) begin push_frame(c, 8'hFF, 1'b0); push_idle(c, 1, 1'b1); end
    end
    push_frame(0, 8'hFF, 1'b0); push_idle(0, 1, 1'b1);
    run_out(2);
    chk("t6 saturated", 32'(err_cnt), 32'd255);
    chk("t6 overrun set", 32'(ovr[1]), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6 cleared err", 32'(err_cnt), 32'd0);
    chk("t6 cleared ovr", 32'(ovr), 32'd0);
    ready_v = 1'b1;
    repeat (6) tick();

    // Randomized traffic against the reference model
    for (int phase = 0; phase < 4; phase++) begin
      int n = 0;
      for (int c = 0; c < NCH; c++) begin
        while (txq[c].size() < 150) begin
          bit good = ($urandom_range(0, 7) != 0);
          push_idle(c, $urandom_range(0, 3), 1'b1);
          push_frame(c, 8'($urandom), good);
          if (!good) push_idle(c, 1, 1'b1);
        end
      end
      while (queues_busy() && n < 4000) begin
        ready_v = ($urandom_range(0, 99) < ((phase % 2 == 0) ? 85 : 25));
        clr = ($urandom_range(0, 63) == 0);
        tick();
        n++;
      end
      clr = 1'b0;
      ready_v = 1'b1;
      chk("random drain bound", 32'(queues_busy()), 32'd0);
      repeat (10) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
